// File: rtl/regfile_writeback_pkg.sv
// Shared types and widths for the register-file write-back path.
// The regfile uses the same address and data widths.
package regfile_writeback_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 64;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    typedef struct packed {
        reg_addr_t addr;
        xlen_t     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_ALU,
        GRANT_LAT
    } grant_e;

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Synchronous FIFO that holds long-latency write-back results.
// A push while full is dropped, even when a pop happens in the same cycle.
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and buffered long-latency results into the single regfile write port.
// Also keeps the busy scoreboard that decode reads for rs1 and rs2.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_wb_en,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd_addr,
    input  logic [XLEN-1:0]       alu_rd_data,
    input  logic                  lat_valid,
    output logic                  lat_ready,
    input  logic [REG_ADDR_W-1:0] lat_rd_addr,
    input  logic [XLEN-1:0]       lat_rd_data,
    input  logic                  issue_en,
    input  logic [REG_ADDR_W-1:0] issue_rd_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  write_en,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_data
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t             lat_entry, fifo_head, win_entry;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                  force_lat;
    grant_e                grant;

    logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic                  write_en_q, write_en_d;
    reg_addr_t             rd_addr_q, rd_addr_d;
    xlen_t                 rd_data_q, rd_data_d;
    logic                  out_is_lat_q, out_is_lat_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    assign lat_entry = '{addr: lat_rd_addr, data: lat_rd_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (lat_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // A queued result that has lost STARVE_LIMIT cycles in a row takes the port from the ALU.
    always_comb begin
        force_lat = ~fifo_empty & (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
        grant     = GRANT_NONE;
        if (!rst) begin
            if (force_lat)        grant = GRANT_LAT;
            else if (alu_wb_en)   grant = GRANT_ALU;
            else if (!fifo_empty) grant = GRANT_LAT;
        end
        alu_ready = ~rst & ~force_lat;
        lat_ready = ~rst & ~fifo_full;
        fifo_push = lat_valid & lat_ready;
        fifo_pop  = (grant == GRANT_LAT);
        win_entry = (grant == GRANT_LAT) ? fifo_head : '{addr: alu_rd_addr, data: alu_rd_data};
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || fifo_pop)
            starve_cnt_d = '0;
        else if (grant == GRANT_ALU && starve_cnt_q != STARVE_W'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end

    // Writes to x0 are consumed but never reach the regfile.
    always_comb begin
        write_en_d   = (grant != GRANT_NONE) && (win_entry.addr != '0);
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        out_is_lat_d = 1'b0;
        if (write_en_d) begin
            rd_addr_d    = win_entry.addr;
            rd_data_d    = win_entry.data;
            out_is_lat_d = (grant == GRANT_LAT);
        end
    end

    // Clear follows the regfile write; a same-cycle issue to that register overrides it.
    always_comb begin
        busy_d = busy_q;
        if (write_en_q && out_is_lat_q) busy_d[rd_addr_q] = 1'b0;
        if (issue_en)                   busy_d[issue_rd_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            write_en_q   <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            out_is_lat_q <= 1'b0;
            busy_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            write_en_q   <= write_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            out_is_lat_q <= out_is_lat_d;
            busy_q       <= busy_d;
        end
    end

    assign write_en = write_en_q;
    assign rd_addr  = rd_addr_q;
    assign rd_data  = rd_data_q;
    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected regfile writes go into a queue,
// and a negedge monitor pops and compares every write_en pulse.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wb_en, alu_ready;
    logic [4:0]  alu_rd_addr;
    logic [63:0] alu_rd_data;
    logic        lat_valid, lat_ready;
    logic [4:0]  lat_rd_addr;
    logic [63:0] lat_rd_data;
    logic        issue_en;
    logic [4:0]  issue_rd_addr, rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        write_en;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;

    int          checks = 0;
    int          errors = 0;
    wb_entry_t   exp_q[$];
    wb_entry_t   mon_e;
    logic        alu_taken, lat_taken;
    int          st;
    int          accepted;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .alu_wb_en     (alu_wb_en),
        .alu_ready     (alu_ready),
        .alu_rd_addr   (alu_rd_addr),
        .alu_rd_data   (alu_rd_data),
        .lat_valid     (lat_valid),
        .lat_ready     (lat_ready),
        .lat_rd_addr   (lat_rd_addr),
        .lat_rd_data   (lat_rd_data),
        .issue_en      (issue_en),
        .issue_rd_addr (issue_rd_addr),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .write_en      (write_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [4:0] a, input logic [63:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    // Handshakes are sampled at negedge; inputs change 1ns after posedge.
    task automatic tick();
        @(negedge clk);
        alu_taken = alu_wb_en & alu_ready;
        lat_taken = lat_valid & lat_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_send(input logic [4:0] a, input logic [63:0] d, output int stalls);
        alu_wb_en   = 1'b1;
        alu_rd_addr = a;
        alu_rd_data = d;
        stalls      = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (alu_taken) return;
            stalls++;
        end
        checks++;
        errors++;
        $display("FAIL alu_send_timeout: rd=%0d never taken", a);
    endtask

    task automatic lat_send(input logic [4:0] a, input logic [63:0] d);
        lat_valid   = 1'b1;
        lat_rd_addr = a;
        lat_rd_data = d;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (lat_taken) begin
                lat_valid = 1'b0;
                return;
            end
        end
        lat_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL lat_send_timeout: rd=%0d never accepted", a);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", rd_addr, rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_addr", 64'(rd_addr), 64'(mon_e.addr));
                check("wb_data", rd_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        alu_wb_en = 1'b0; alu_rd_addr = '0; alu_rd_data = '0;
        lat_valid = 1'b0; lat_rd_addr = '0; lat_rd_data = '0;
        issue_en = 1'b0; issue_rd_addr = '0; rs1_addr = '0; rs2_addr = '0;
        tick();
        tick();
        check("rst_write_en", 64'(write_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_lat_ready", 64'(lat_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_alu_ready", 64'(alu_ready), 64'd1);
        check("post_rst_lat_ready", 64'(lat_ready), 64'd1);

        // 1: ALU write appears exactly one cycle later, then nothing
        expect_wb(5'd5, 64'h1234);
        alu_send(5'd5, 64'h1234, st);
        alu_wb_en = 1'b0;
        check("t1_write_en_n1", 64'(write_en), 64'd1);
        check("t1_rd_addr", 64'(rd_addr), 64'd5);
        check("t1_rd_data", rd_data, 64'h1234);
        tick();
        check("t1_write_en_n2", 64'(write_en), 64'd0);

        // 2: busy held until the write cycle, gone the cycle after
        issue_en = 1'b1; issue_rd_addr = 5'd7; rs1_addr = 5'd7;
        tick();
        issue_en = 1'b0;
        check("t2_busy_after_issue", 64'(rs1_busy), 64'd1);
        tick();
        tick();
        expect_wb(5'd7, 64'hAB);
        lat_send(5'd7, 64'hAB);
        check("t2_busy_pop_cycle", 64'(rs1_busy), 64'd1);
        tick();
        check("t2_write_en", 64'(write_en), 64'd1);
        check("t2_busy_write_cycle", 64'(rs1_busy), 64'd1);
        tick();
        check("t2_busy_cleared", 64'(rs1_busy), 64'd0);

        // 3: ALU saturating, one queued result is forced through after 3 lost cycles
        for (int i = 0; i < 4; i++) expect_wb(5'(2 + i), 64'hA0 + 64'(i));
        expect_wb(5'd11, 64'h111);
        for (int i = 4; i < 6; i++) expect_wb(5'(2 + i), 64'hA0 + 64'(i));
        lat_valid = 1'b1; lat_rd_addr = 5'd11; lat_rd_data = 64'h111;
        for (int i = 0; i < 6; i++) begin
            alu_send(5'(2 + i), 64'hA0 + 64'(i), st);
            if (i == 0) begin
                check("t3_lat_push", 64'(lat_taken), 64'd1);
                lat_valid = 1'b0;
            end
            check($sformatf("t3_stalls_%0d", i), 64'(st), (i == 4) ? 64'd1 : 64'd0);
        end
        alu_wb_en = 1'b0;
        wait_drain();

        // 4: five pushes into a depth-4 FIFO while the ALU (to x0) hogs the port
        alu_wb_en = 1'b1; alu_rd_addr = 5'd0; alu_rd_data = '1;
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            expect_wb(5'(12 + i), 64'h400 + 64'(i));
            lat_send(5'(12 + i), 64'h400 + 64'(i));
            accepted++;
            if (accepted == 4) check("t4_lat_ready_full", 64'(lat_ready), 64'd0);
        end
        repeat (24) tick();
        alu_wb_en = 1'b0;
        wait_drain();

        // 5: x0 from both sources never writes; busy of another register untouched
        issue_en = 1'b1; issue_rd_addr = 5'd20;
        tick();
        issue_rd_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd20;
        tick();
        issue_en = 1'b0;
        check("t5_busy_x0", 64'(rs1_busy), 64'd0);
        check("t5_busy_x20", 64'(rs2_busy), 64'd1);
        alu_wb_en = 1'b1; alu_rd_addr = 5'd0; alu_rd_data = 64'hDEAD;
        lat_valid = 1'b1; lat_rd_addr = 5'd0; lat_rd_data = 64'h55;
        tick();
        check("t5_alu_taken", 64'(alu_taken), 64'd1);
        check("t5_lat_taken", 64'(lat_taken), 64'd1);
        alu_wb_en = 1'b0; lat_valid = 1'b0;
        check("t5_no_write_alu", 64'(write_en), 64'd0);
        tick();
        check("t5_no_write_pop", 64'(write_en), 64'd0);
        tick();
        check("t5_no_write_lat", 64'(write_en), 64'd0);
        check("t5_busy_x20_kept", 64'(rs2_busy), 64'd1);

        // 6: re-issue of x9 in its retire cycle keeps it busy
        issue_en = 1'b1; issue_rd_addr = 5'd9; rs1_addr = 5'd9;
        tick();
        issue_en = 1'b0;
        check("t6_busy_issue", 64'(rs1_busy), 64'd1);
        expect_wb(5'd9, 64'h99);
        lat_send(5'd9, 64'h99);
        tick();
        check("t6_write_en", 64'(write_en), 64'd1);
        issue_en = 1'b1; issue_rd_addr = 5'd9;
        tick();
        issue_en = 1'b0;
        check("t6_set_wins", 64'(rs1_busy), 64'd1);

        // reset with two entries queued behind a busy ALU
        alu_wb_en = 1'b1; alu_rd_addr = 5'd0; alu_rd_data = 64'h0;
        lat_send(5'd21, 64'h2121);
        lat_send(5'd22, 64'h2222);
        rst = 1'b1;
        #1;
        check("t6_rst_alu_ready", 64'(alu_ready), 64'd0);
        check("t6_rst_lat_ready", 64'(lat_ready), 64'd0);
        tick();
        rst = 1'b0;
        alu_wb_en = 1'b0;
        rs2_addr = 5'd20;
        #1;
        check("t6_rst_write_en", 64'(write_en), 64'd0);
        check("t6_rst_rd_addr", 64'(rd_addr), 64'd0);
        check("t6_rst_busy9", 64'(rs1_busy), 64'd0);
        check("t6_rst_busy20", 64'(rs2_busy), 64'd0);
        check("t6_rst_lat_ready", 64'(lat_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6_rst_idle_%0d", i), 64'(write_en), 64'd0);
        end

        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
